ptw_mem_port: RTL and testbench

//   Responder end of the MMU page-table-walk memory port. Accepts single-word PTE reads from the IFU MMU.

---
 rtl/ptw_mem_port.sv | 182 ++++++++++++++++++
 tb/tb_ptw_mem_port.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_mem_port.sv
// Page-table-walk memory port: PTE reads from the MMU, served over a
// single-outstanding read channel with a 1-entry last-PTE buffer.
module ptw_mem_port #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int PTE_BUF_EN     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mmu_mem_req_i,
    input  logic [31:0] mmu_mem_addr_i,
    input  logic        mmu_flush_i,
    output logic [31:0] mmu_mem_rdata_o,
    output logic        mmu_mem_rvalid_o,
    output logic        mmu_mem_fault_o,
    output logic        ptw_arvalid_o,
    output logic [31:0] ptw_araddr_o,
    input  logic        ptw_arready_i,
    input  logic        ptw_rvalid_i,
    input  logic [31:0] ptw_rdata_i,
    input  logic [1:0]  ptw_rresp_i,
    output logic        ptw_rready_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [15:0] r_cnt;
    logic        r_abort;
    logic        r_to;
    logic        r_buf_valid;
    logic [31:0] r_buf_tag;
    logic [31:0] r_buf_data;

    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;
    logic        w_fill;
    logic        w_misalign;
    logic        w_hit;
    logic        w_resp;

    assign w_misalign = |mmu_mem_addr_i[1:0];
    assign w_hit      = (PTE_BUF_EN != 0) && r_buf_valid
                        && (r_buf_tag == mmu_mem_addr_i);

    // Next-state and per-cycle control strobes
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_fill    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (mmu_mem_req_i && !mmu_flush_i) begin
                    w_accept = 1'b1;
                    if (w_misalign || w_hit) w_next = S_RESP;
                    else                     w_next = S_AR;
                end
            end
            S_AR: begin
                if (ptw_arready_i) begin
                    if (r_abort || mmu_flush_i) w_next = S_DRAIN;
                    else                        w_next = S_R;
                end
            end
            S_R: begin
                if (ptw_rvalid_i) begin
                    if (mmu_flush_i) begin
                        w_next = S_IDLE;
                    end else begin
                        w_capture = 1'b1;
                        w_fill    = (ptw_rresp_i == 2'b00);
                        w_next    = S_RESP;
                    end
                end else if (mmu_flush_i) begin
                    w_next = S_DRAIN;
                end else if (r_cnt == LP_TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                w_next = r_to ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (ptw_rvalid_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // R-phase cycle counter, held at zero outside R
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_cnt <= '0;
        else if (r_state == S_R) r_cnt <= r_cnt + 16'd1;
        else                     r_cnt <= '0;
    end

    // Remembers a flush seen while the address beat is still pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_abort <= 1'b0;
        else if (r_state == S_AR && !ptw_arready_i)
            r_abort <= r_abort | mmu_flush_i;
        else
            r_abort <= 1'b0;
    end

    // Timed-out read still owes a beat: route RESP into DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_to <= 1'b0;
        else if (w_timeout)         r_to <= 1'b1;
        else if (r_state == S_RESP) r_to <= 1'b0;
    end

    // Address latch and response data/fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_addr <= mmu_mem_addr_i;
            if (w_misalign) begin
                r_rdata <= '0;
                r_fault <= 1'b1;
            end else if (w_hit) begin
                r_rdata <= r_buf_data;
                r_fault <= 1'b0;
            end
        end else if (w_capture) begin
            r_rdata <= ptw_rdata_i;
            r_fault <= |ptw_rresp_i;
        end else if (w_timeout) begin
            r_rdata <= '0;
            r_fault <= 1'b1;
        end
    end

    // Last-PTE buffer: flush wins over a coincident fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if (mmu_flush_i) begin
            r_buf_valid <= 1'b0;
        end else if (w_fill) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_addr;
            r_buf_data  <= ptw_rdata_i;
        end
    end

    assign w_resp           = (r_state == S_RESP) && !mmu_flush_i;
    assign mmu_mem_rvalid_o = w_resp;
    assign mmu_mem_rdata_o  = w_resp ? r_rdata : '0;
    assign mmu_mem_fault_o  = w_resp & r_fault;
    assign ptw_arvalid_o    = (r_state == S_AR);
    assign ptw_araddr_o     = r_addr;
    assign ptw_rready_o     = (r_state == S_R) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_ptw_mem_port.sv
// Directed bench for ptw_mem_port: vector table of walks plus
// hand sequences for timeout, flush and reset corner cases.
module tb_ptw_mem_port;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] o_rdata;
    logic        o_rvalid;
    logic        o_fault;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    int total;
    int bad;

    ptw_mem_port #(
        .TIMEOUT_CYCLES(8),
        .PTE_BUF_EN(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mmu_mem_req_i(req),
        .mmu_mem_addr_i(addr),
        .mmu_flush_i(flush),
        .mmu_mem_rdata_o(o_rdata),
        .mmu_mem_rvalid_o(o_rvalid),
        .mmu_mem_fault_o(o_fault),
        .ptw_arvalid_o(arvalid),
        .ptw_araddr_o(araddr),
        .ptw_arready_i(arready),
        .ptw_rvalid_i(rvalid),
        .ptw_rdata_i(rdata),
        .ptw_rresp_i(rresp),
        .ptw_rready_o(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          ar_dly;
        int          r_dly;
        logic [31:0] bdata;
        logic [1:0]  bresp;
        bit          pflush;
        bit          exp_ar;
        int          exp_lat;
        logic [31:0] exp_rd;
        bit          exp_ft;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One MMU walk with a delayed-response bus model; entered and left
    // at posedge+1.
    task automatic run_vec(input vec_t v, input string nm);
        bit          done;
        bit          got_ar;
        bit          ok;
        logic [31:0] got_addr;
        logic [31:0] got_rd;
        logic        got_ft;
        int          lat;
        int          ar_cnt;
        int          r_cnt;
        done = 0; got_ar = 0; ok = 1; got_addr = '0;
        got_rd = '0; got_ft = 1'b0; lat = -1; ar_cnt = 0; r_cnt = 0;
        if (v.pflush) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        req  = 1'b1;
        addr = v.addr;
        for (int c = 0; c < 200 && !done; c++) begin
            arready = arvalid && (ar_cnt >= v.ar_dly);
            rvalid  = rready && (r_cnt >= v.r_dly);
            rdata   = rvalid ? v.bdata : 32'h0;
            rresp   = rvalid ? v.bresp : 2'b00;
            @(negedge clk);
            if (arvalid) begin
                if (got_ar && araddr !== got_addr) ok = 0;
                got_ar   = 1;
                got_addr = araddr;
                ar_cnt++;
            end
            if (rready) r_cnt++;
            if (o_rvalid) begin
                done   = 1;
                lat    = c;
                got_rd = o_rdata;
                got_ft = o_fault;
            end else if (o_rdata !== 32'h0 || o_fault !== 1'b0) begin
                ok = 0;
            end
            @(posedge clk); #1;
        end
        req = 1'b0; arready = 1'b0; rvalid = 1'b0;
        rdata = 32'h0; rresp = 2'b00;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, "_rdata"}, got_rd, v.exp_rd);
        chk({nm, "_fault"}, 32'(got_ft), 32'(v.exp_ft));
        chk({nm, "_ar"}, 32'(got_ar), 32'(v.exp_ar));
        chk({nm, "_proto"}, 32'(ok), 32'd1);
        if (v.exp_ar) chk({nm, "_araddr"}, got_addr, v.addr);
    endtask

    function automatic vec_t miss(input logic [31:0] a,
                                  input logic [31:0] d);
        vec_t v;
        v = '{a, 0, 0, d, 2'b00, 1'b0, 1'b1, 3, d, 1'b0};
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        int          ent;
        int          pulse;
        bit          ok;
        bit          saw;
        logic [31:0] trd;
        logic        tft;

        total = 0; bad = 0;
        rst_n = 1'b0; req = 1'b0; addr = '0; flush = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        tbl[0]  = '{32'h8000_1004, 0, 0, 32'h2000_0C01, 2'b00, 1'b0,
                    1'b1, 3, 32'h2000_0C01, 1'b0};
        tbl[1]  = '{32'h8000_1004, 0, 0, 32'h0, 2'b00, 1'b0,
                    1'b0, 1, 32'h2000_0C01, 1'b0};
        tbl[2]  = '{32'h8000_1004, 0, 0, 32'h2000_0C01, 2'b00, 1'b1,
                    1'b1, 3, 32'h2000_0C01, 1'b0};
        tbl[3]  = '{32'h8000_2000, 0, 0, 32'hDEAD_BEEF, 2'b10, 1'b0,
                    1'b1, 3, 32'hDEAD_BEEF, 1'b1};
        tbl[4]  = '{32'h8000_2000, 1, 0, 32'h1111_0001, 2'b00, 1'b0,
                    1'b1, 4, 32'h1111_0001, 1'b0};
        tbl[5]  = '{32'h8000_3002, 0, 0, 32'h0, 2'b00, 1'b0,
                    1'b0, 1, 32'h0, 1'b1};
        tbl[6]  = '{32'h8000_4008, 2, 3, 32'h0000_00CF, 2'b00, 1'b0,
                    1'b1, 8, 32'h0000_00CF, 1'b0};
        tbl[7]  = '{32'h8000_4008, 0, 0, 32'h0, 2'b00, 1'b0,
                    1'b0, 1, 32'h0000_00CF, 1'b0};
        tbl[8]  = '{32'h8000_2000, 0, 1, 32'h3333_0001, 2'b00, 1'b0,
                    1'b1, 4, 32'h3333_0001, 1'b0};
        tbl[9]  = '{32'h8000_2000, 0, 0, 32'h4444_0001, 2'b00, 1'b1,
                    1'b1, 3, 32'h4444_0001, 1'b0};
        tbl[10] = '{32'h8000_2000, 0, 0, 32'h0, 2'b00, 1'b0,
                    1'b0, 1, 32'h4444_0001, 1'b0};
        tbl[11] = '{32'h8000_A000, 0, 0, 32'h1234_5678, 2'b01, 1'b0,
                    1'b1, 3, 32'h1234_5678, 1'b1};
        tbl[12] = '{32'h8000_3001, 0, 0, 32'h0, 2'b00, 1'b0,
                    1'b0, 1, 32'h0, 1'b1};

        #12;
        chk("rst_ctl", {28'h0, arvalid, rready, o_rvalid, o_fault}, 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        // Timeout: address accepted, data never comes back
        req = 1'b1; addr = 32'h8000_5000; arready = 1'b1;
        ent = -1; pulse = -1; trd = '0; tft = 1'b0;
        for (int c = 0; c < 40 && pulse < 0; c++) begin
            @(negedge clk);
            if (rready && ent < 0) ent = c;
            if (o_rvalid) begin
                pulse = c; trd = o_rdata; tft = o_fault;
            end
            @(posedge clk); #1;
        end
        arready = 1'b0;
        chk("to_lat", 32'(pulse - ent), 32'd8);
        chk("to_fault", 32'(tft), 32'd1);
        chk("to_rdata", trd, 32'h0);
        addr = 32'h8000_6000;
        ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (arvalid || !rready || o_rvalid) ok = 0;
            @(posedge clk); #1;
        end
        chk("to_drain", 32'(ok), 32'd1);
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        @(posedge clk); #1;
        rvalid = 1'b0; rdata = 32'h0;
        run_vec(miss(32'h8000_6000, 32'h5555_0001), "to_after");

        // Flush while the address beat is stalled
        req = 1'b1; addr = 32'h8000_7000;
        @(posedge clk); #1;
        flush = 1'b1; req = 1'b0;
        ok = 1; saw = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!arvalid || araddr !== 32'h8000_7000) ok = 0;
            if (o_rvalid) saw = 1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        arready = 1'b1;
        @(negedge clk);
        if (!arvalid) ok = 0;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("fl_ar_hold", 32'(ok), 32'd1);
        ok = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!rready || arvalid) ok = 0;
            if (o_rvalid) saw = 1;
            @(posedge clk); #1;
        end
        chk("fl_drain", 32'(ok), 32'd1);
        rvalid = 1'b1; rdata = 32'h0BAD_0001;
        @(negedge clk);
        @(posedge clk); #1;
        rvalid = 1'b0; rdata = 32'h0;
        ok = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rready || arvalid || o_rvalid) ok = 0;
            @(posedge clk); #1;
        end
        chk("fl_idle", 32'(ok), 32'd1);
        chk("fl_no_resp", 32'(saw), 32'd0);
        run_vec(miss(32'h8000_7000, 32'h6666_0001), "fl_after");

        // Flush in R together with the data beat
        req = 1'b1; addr = 32'h8000_8000; arready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("flr_in_r", 32'(rready), 32'd1);
        flush = 1'b1; rvalid = 1'b1; rdata = 32'h7777_0001; req = 1'b0;
        @(negedge clk);
        chk("flr_no_pulse", 32'(o_rvalid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        @(negedge clk);
        chk("flr_idle", {29'h0, rready, arvalid, o_rvalid}, 32'h0);
        @(posedge clk); #1;
        run_vec(miss(32'h8000_8000, 32'h8888_0001), "flr_after");

        // Flush during a hit response
        req = 1'b1; addr = 32'h8000_8000;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flresp_sup", 32'(o_rvalid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req = 1'b0;
        run_vec(miss(32'h8000_8000, 32'h9999_0001), "flresp_after");

        // Reset asserted while in R
        req = 1'b1; addr = 32'h8000_9000; arready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("rstr_in_r", 32'(rready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstr_ctl", {28'h0, arvalid, rready, o_rvalid, o_fault}, 32'h0);
        chk("rstr_araddr", araddr, 32'h0);
        chk("rstr_rdata", o_rdata, 32'h0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(miss(32'h8000_8000, 32'hAAAA_0001), "rstr_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
